ext_value_seq: RTL and testbench

- Registered value-formatting engine: takes narrow input words and emits OUT_W-bit results, each in one of four modes:
  - zero-extend
  - sign-extend
  - single lookup in a fixed 16-entry constant table
  - multi-word burst from the table
- Successor to the combinational extension/constant-select logic. Adds parametrised widths, a valid/ready handshake on both sides and a burst sequencer.
- Sits between a command source and any consumer needing sized constants or extended operands.

---
 rtl/ext_value_seq.sv | 152 +++++++++++++++
 tb/tb_ext_value_seq.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_value_seq.sv
// Registered value formatter: zero/sign extension, constant-table lookup and table bursts
// with valid/ready on both sides. Define EXT_SAT_EN to saturate rather than truncate on narrowing.
module ext_value_seq #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 29,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [IN_W-1:0]  in_a,
    input  logic [LEN_W-1:0] in_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_y,
    output logic             out_last
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t             state, state_nxt;
    logic [3:0]         idx_next, idx_next_nxt;
    logic [LEN_W-1:0]   remaining, remaining_nxt;
    logic               out_valid_nxt, out_last_nxt;
    logic [OUT_W-1:0]   out_y_nxt;
    logic [OUT_W-1:0]   cmd_word, burst_word;
    logic               accept;

    function automatic logic [28:0] table_word(input logic [3:0] idx);
        logic [28:0] w;
        unique case (idx)
            4'd0:  w = 29'h0;
            4'd1:  w = 29'hB;
            4'd2:  w = 29'hDE;
            4'd3:  w = 29'hD80;
            4'd4:  w = 29'h92;
            4'd5:  w = 29'h123ABC;
            4'd6:  w = 29'h53977;
            4'd7:  w = 29'h34BF15;
            4'd8:  w = 29'h92;
            4'd9:  w = 29'h3ABC;
            4'd10: w = 29'h3977;
            4'd11: w = 29'hBF15;
            4'd12: w = 29'h0F626172;
            4'd13: w = 29'h0F626172;
            4'd14: w = 29'h1;
            default: w = 29'hF;
        endcase
        return w;
    endfunction

`ifdef EXT_SAT_EN
    localparam logic [64:0]        UMAX = (65'd1 << OUT_W) - 65'd1;
    localparam logic signed [64:0] SMAX = (65'sd1 <<< (OUT_W - 1)) - 65'sd1;
    localparam logic signed [64:0] SMIN = -(65'sd1 <<< (OUT_W - 1));

    function automatic logic [OUT_W-1:0] fmt_unsigned(input logic [63:0] v);
        if ({1'b0, v} > UMAX) return UMAX[OUT_W-1:0];
        return v[OUT_W-1:0];
    endfunction

    function automatic logic [OUT_W-1:0] fmt_signed(input logic [63:0] v);
        logic signed [64:0] w;
        w = $signed({v[63], v});
        if (w > SMAX) return SMAX[OUT_W-1:0];
        if (w < SMIN) return SMIN[OUT_W-1:0];
        return v[OUT_W-1:0];
    endfunction
`else
    // Both extensions reduce to keeping the low bits of a 64-bit extended value.
    function automatic logic [OUT_W-1:0] fmt_unsigned(input logic [63:0] v);
        return v[OUT_W-1:0];
    endfunction

    function automatic logic [OUT_W-1:0] fmt_signed(input logic [63:0] v);
        return v[OUT_W-1:0];
    endfunction
`endif

    assign in_ready = rst_n && (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        cmd_word = '0;
        unique case (in_mode)
            2'd0:    cmd_word = fmt_unsigned(64'(in_a));
            2'd1:    cmd_word = fmt_signed({{(64 - IN_W){in_a[IN_W-1]}}, in_a});
            default: cmd_word = fmt_unsigned(64'(table_word(in_a[3:0])));
        endcase
        burst_word = fmt_unsigned(64'(table_word(idx_next)));
    end

    always_comb begin
        state_nxt     = state;
        idx_next_nxt  = idx_next;
        remaining_nxt = remaining;
        out_valid_nxt = out_valid;
        out_y_nxt     = out_y;
        out_last_nxt  = out_last;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    out_valid_nxt = 1'b1;
                    out_y_nxt     = cmd_word;
                    out_last_nxt  = 1'b1;
                    // A one-word burst is just a lookup; only longer ones need the sequencer.
                    if (in_mode == 2'd3 && in_len != '0) begin
                        out_last_nxt  = 1'b0;
                        remaining_nxt = in_len;
                        idx_next_nxt  = in_a[3:0] + 4'd1;
                        state_nxt     = BURST;
                    end
                end else if (out_ready) begin
                    out_valid_nxt = 1'b0;
                end
            end
            BURST: begin
                if (out_ready) begin
                    out_y_nxt     = burst_word;
                    idx_next_nxt  = idx_next + 4'd1;
                    remaining_nxt = remaining - LEN_W'(1);
                    if (remaining == LEN_W'(1)) begin
                        out_last_nxt = 1'b1;
                        state_nxt    = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx_next  <= '0;
            remaining <= '0;
            out_valid <= 1'b0;
            out_y     <= '0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx_next  <= idx_next_nxt;
            remaining <= remaining_nxt;
            out_valid <= out_valid_nxt;
            out_y     <= out_y_nxt;
            out_last  <= out_last_nxt;
        end
    end

endmodule

// File: tb/tb_ext_value_seq.sv
// Bench for ext_value_seq: directed cases on three width configurations, then randomized
// commands with random back-pressure checked against an arithmetic reference model.
module tb_ext_value_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic out_ready;

    logic       a_in_valid, a_in_ready, a_out_valid, a_out_last;
    logic [1:0] a_in_mode;
    logic [3:0] a_in_a, a_in_len;
    logic [7:0] a_out_y;

    logic        bc_in_valid;
    logic [1:0]  bc_in_mode;
    logic [11:0] bc_in_a;
    logic [3:0]  bc_in_len;
    logic        b_in_ready, b_out_valid, b_out_last;
    logic [7:0]  b_out_y;
    logic        c_in_ready, c_out_valid, c_out_last;
    logic [28:0] c_out_y;

    ext_value_seq #(.IN_W(4), .OUT_W(8), .LEN_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_mode(a_in_mode), .in_a(a_in_a), .in_len(a_in_len), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_y(a_out_y), .out_last(a_out_last));

    ext_value_seq #(.IN_W(12), .OUT_W(8), .LEN_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(bc_in_valid), .in_ready(b_in_ready),
        .in_mode(bc_in_mode), .in_a(bc_in_a), .in_len(bc_in_len), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_y(b_out_y), .out_last(b_out_last));

    ext_value_seq #(.IN_W(12), .OUT_W(29), .LEN_W(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(bc_in_valid), .in_ready(c_in_ready),
        .in_mode(bc_in_mode), .in_a(bc_in_a), .in_len(bc_in_len), .out_valid(c_out_valid),
        .out_ready(out_ready), .out_y(c_out_y), .out_last(c_out_last));

    int total = 0;
    int bad = 0;
    longint exp_q[$];
    bit     last_q[$];

    logic [28:0] tbl [0:15] = '{29'h0, 29'hB, 29'hDE, 29'hD80, 29'h92, 29'h123ABC, 29'h53977,
                                29'h34BF15, 29'h92, 29'h3ABC, 29'h3977, 29'hBF15,
                                29'h0F626172, 29'h0F626172, 29'h1, 29'hF};

    // Reference value: take the operand as an integer, clamp if saturating, reduce mod 2^out_w.
    function automatic longint model(input int mode, input longint a, input int in_w, input int out_w);
        longint v, mask, hi, lo;
        if (mode == 0) v = a;
        else if (mode == 1) v = (a >= (longint'(1) << (in_w - 1))) ? a - (longint'(1) << in_w) : a;
        else v = longint'(tbl[a % 16]);
        mask = (longint'(1) << out_w) - 1;
`ifdef EXT_SAT_EN
        if (mode == 1) begin
            hi = (longint'(1) << (out_w - 1)) - 1;
            lo = -(longint'(1) << (out_w - 1));
            if (v > hi) v = hi;
            if (v < lo) v = lo;
        end else if (v > mask) begin
            v = mask;
        end
`else
        hi = 0;
        lo = 0;
`endif
        return v & mask;
    endfunction

    task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic checkOutput(input string tag, input int which, input logic [63:0] exp_y,
                               input logic exp_last);
        logic v, l;
        logic [63:0] y;
        int n = 0;
        do begin
            @(negedge clk);
            n++;
            case (which)
                0:       begin v = a_out_valid; y = 64'(a_out_y); l = a_out_last; end
                1:       begin v = b_out_valid; y = 64'(b_out_y); l = b_out_last; end
                default: begin v = c_out_valid; y = 64'(c_out_y); l = c_out_last; end
            endcase
        end while (!v && n < 50);
        checkEq({tag, ".valid"}, 64'(v), 64'd1);
        checkEq({tag, ".y"}, y, exp_y);
        checkEq({tag, ".last"}, 64'(l), 64'(exp_last));
    endtask

    task automatic applyStimulus(input logic [1:0] mode, input logic [3:0] a, input logic [3:0] len);
        int n = 0;
        @(posedge clk); #1;
        a_in_valid = 1'b1; a_in_mode = mode; a_in_a = a; a_in_len = len;
        do begin @(negedge clk); n++; end while (!a_in_ready && n < 50);
        checkEq("accept_a", 64'(a_in_ready), 64'd1);
        @(posedge clk); #1;
        a_in_valid = 1'b0;
    endtask

    task automatic applyStimulusBC(input logic [1:0] mode, input logic [11:0] a);
        int n = 0;
        @(posedge clk); #1;
        bc_in_valid = 1'b1; bc_in_mode = mode; bc_in_a = a; bc_in_len = 4'd0;
        do begin @(negedge clk); n++; end while (!(b_in_ready && c_in_ready) && n < 50);
        checkEq("accept_bc", 64'(b_in_ready && c_in_ready), 64'd1);
        @(posedge clk); #1;
        bc_in_valid = 1'b0;
    endtask

    // Called at a negedge: retire a word leaving A, then log a command entering A.
    task automatic sampleA();
        int n;
        if (a_out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checkEq("rand_unexpected_word", 64'(a_out_valid), 64'd0);
            end else begin
                checkEq("rand.y", 64'(a_out_y), 64'(exp_q[0]));
                checkEq("rand.last", 64'(a_out_last), 64'(last_q[0]));
                void'(exp_q.pop_front());
                void'(last_q.pop_front());
            end
        end
        if (a_in_valid && a_in_ready) begin
            n = (a_in_mode == 2'd3) ? int'(a_in_len) + 1 : 1;
            for (int k = 0; k < n; k++) begin
                if (a_in_mode == 2'd3) exp_q.push_back(model(2, longint'((a_in_a + k) % 16), 4, 8));
                else exp_q.push_back(model(int'(a_in_mode), longint'(a_in_a), 4, 8));
                last_q.push_back(k == n - 1);
            end
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0; out_ready = 1'b1;
        a_in_valid = 1'b0; a_in_mode = '0; a_in_a = '0; a_in_len = '0;
        bc_in_valid = 1'b0; bc_in_mode = '0; bc_in_a = '0; bc_in_len = '0;
        #12;
        checkEq("rst.valid", 64'(a_out_valid), 64'd0);
        checkEq("rst.y", 64'(a_out_y), 64'd0);
        checkEq("rst.last", 64'(a_out_last), 64'd0);
        checkEq("rst.in_ready", 64'(a_in_ready), 64'd0);
        rst_n = 1'b1;

        $display("[TB] directed formatting");
        applyStimulus(2'd1, 4'b1010, 4'd0);
        checkOutput("sext_a", 0, 64'hFA, 1'b1);
        @(negedge clk);
        checkEq("valid_clears", 64'(a_out_valid), 64'd0);
        applyStimulus(2'd0, 4'b1010, 4'd0);
        checkOutput("zext_a", 0, 64'h0A, 1'b1);
`ifdef EXT_SAT_EN
        applyStimulus(2'd2, 4'd3, 4'd0);  checkOutput("tbl3", 0, 64'hFF, 1'b1);
        applyStimulus(2'd2, 4'd7, 4'd0);  checkOutput("tbl7", 0, 64'hFF, 1'b1);
        applyStimulus(2'd2, 4'd12, 4'd0); checkOutput("tbl12", 0, 64'hFF, 1'b1);
`else
        applyStimulus(2'd2, 4'd3, 4'd0);  checkOutput("tbl3", 0, 64'h80, 1'b1);
        applyStimulus(2'd2, 4'd7, 4'd0);  checkOutput("tbl7", 0, 64'h15, 1'b1);
        applyStimulus(2'd2, 4'd12, 4'd0); checkOutput("tbl12", 0, 64'h72, 1'b1);
`endif
        checkEq("idle_in_ready", 64'(a_in_ready), 64'd1);
        applyStimulus(2'd3, 4'd4, 4'd0);
        checkOutput("burst_len0", 0, 64'h92, 1'b1);

        $display("[TB] burst under continuous ready");
        applyStimulus(2'd3, 4'd14, 4'd2);
        checkOutput("burst_w0", 0, 64'h01, 1'b0);
        checkEq("burst_in_ready0", 64'(a_in_ready), 64'd0);
        checkOutput("burst_w1", 0, 64'h0F, 1'b0);
        checkEq("burst_in_ready1", 64'(a_in_ready), 64'd0);
        checkOutput("burst_w2", 0, 64'h00, 1'b1);

        $display("[TB] burst with stall");
        @(posedge clk); #1;
        out_ready = 1'b0;
        applyStimulus(2'd3, 4'd14, 4'd2);
        checkOutput("stall_w0", 0, 64'h01, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkEq("stall_hold.y", 64'(a_out_y), 64'h01);
            checkEq("stall_hold.valid", 64'(a_out_valid), 64'd1);
        end
        out_ready = 1'b1;
        checkOutput("stall_w1", 0, 64'h0F, 1'b0);
        checkOutput("stall_w2", 0, 64'h00, 1'b1);

        $display("[TB] reset mid-burst");
        applyStimulus(2'd3, 4'd0, 4'd5);
        checkOutput("rb_w0", 0, 64'h00, 1'b0);
        checkOutput("rb_w1", 0, 64'h0B, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        checkEq("rb_async.valid", 64'(a_out_valid), 64'd0);
        checkEq("rb_async.in_ready", 64'(a_in_ready), 64'd0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkEq("rb_after.valid", 64'(a_out_valid), 64'd0);
            checkEq("rb_after.in_ready", 64'(a_in_ready), 64'd1);
        end

        $display("[TB] wide operand and default width");
        out_ready = 1'b0;
        applyStimulusBC(2'd1, 12'h800);
`ifdef EXT_SAT_EN
        checkOutput("b_sext800", 1, 64'h80, 1'b1);
`else
        checkOutput("b_sext800", 1, 64'h00, 1'b1);
`endif
        checkOutput("c_sext800", 2, 64'h1FFFF800, 1'b1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        applyStimulusBC(2'd2, 12'd5);
`ifdef EXT_SAT_EN
        checkOutput("b_tbl5", 1, 64'hFF, 1'b1);
`else
        checkOutput("b_tbl5", 1, 64'hBC, 1'b1);
`endif
        checkOutput("c_tbl5", 2, 64'h123ABC, 1'b1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        applyStimulusBC(2'd2, 12'd12);
        checkOutput("c_tbl12", 2, 64'h0F626172, 1'b1);
        out_ready = 1'b1;

        $display("[TB] randomized traffic");
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk); #1;
            out_ready  = ($urandom_range(3) != 0);
            a_in_valid = 1'($urandom_range(1));
            a_in_mode  = 2'($urandom_range(3));
            a_in_a     = 4'($urandom);
            a_in_len   = ($urandom_range(3) == 0) ? 4'($urandom) : 4'($urandom_range(2));
            @(negedge clk);
            sampleA();
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        out_ready  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            sampleA();
            n++;
        end while ((exp_q.size() != 0 || a_out_valid) && n < 100);
        checkEq("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
